// File: rtl/quantum_timer_if.sv
// Control/status bundle between the control unit and the quantum timer.
// The master drives the process-control strobes and observes timer status;
// the timer itself sits on the slave side.
interface quantum_timer_if #(
    parameter int WIDTH = 32
);
    logic             Set_Quantum;
    logic [WIDTH-1:0] Quantum_In;
    logic             Start;
    logic             Instr_Valid;
    logic             Halt;
    logic             Context_Ack;
    logic             quantum_end;
    logic             Preempt;
    logic             Running;
    logic [WIDTH-1:0] Remaining;

    modport master (
        output Set_Quantum, Quantum_In, Start, Instr_Valid, Halt, Context_Ack,
        input  quantum_end, Preempt, Running, Remaining
    );

    modport slave (
        input  Set_Quantum, Quantum_In, Start, Instr_Valid, Halt, Context_Ack,
        output quantum_end, Preempt, Running, Remaining
    );
endinterface

// File: rtl/quantum_timer.sv
// Preemption timer: counts retired user instructions and, when the programmed
// quantum runs out, emits a one-cycle quantum_end pulse (which makes the
// offset adder drop back to base 0) and holds Preempt until the control unit
// acknowledges that the context has been saved.
module quantum_timer #(
    parameter int WIDTH           = 32,
    parameter int DEFAULT_QUANTUM = 64
) (
    input logic            Clock,
    input logic            Reset,
    quantum_timer_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        PREEMPT = 2'd2
    } state_t;

    localparam logic [WIDTH-1:0] ZERO      = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE       = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] DEFAULT_Q = DEFAULT_QUANTUM[WIDTH-1:0];

    state_t           state_r;
    state_t           state_next_s;
    logic [WIDTH-1:0] count_r;
    logic [WIDTH-1:0] count_next_s;
    logic [WIDTH-1:0] quantum_r;
    logic [WIDTH-1:0] quantum_next_s;
    logic             quantum_end_r;
    logic             quantum_end_next_s;

    // Quantum register update; a zero length is rejected so the timer can
    // never be armed with an empty quantum. Start uses this value, so a
    // same-cycle Set_Quantum/Start picks up the new length.
    always_comb begin
        quantum_next_s = quantum_r;
        if (bus.Set_Quantum && (bus.Quantum_In != ZERO)) begin
            quantum_next_s = bus.Quantum_In;
        end else begin
            quantum_next_s = quantum_r;
        end
    end

    // Next-state, next-count and expiry-pulse decode.
    always_comb begin
        state_next_s       = state_r;
        count_next_s       = count_r;
        quantum_end_next_s = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.Start) begin
                    state_next_s = RUN;
                    count_next_s = quantum_next_s;
                end else begin
                    state_next_s = IDLE;
                    count_next_s = count_r;
                end
            end
            RUN: begin
                if (bus.Halt) begin
                    state_next_s = IDLE;
                    count_next_s = ZERO;
                end else if (bus.Start) begin
                    // Restart: the instruction retiring this cycle belongs to
                    // the previous launch and is not counted.
                    count_next_s = quantum_next_s;
                end else if (bus.Instr_Valid && (count_r == ONE)) begin
                    state_next_s       = PREEMPT;
                    count_next_s       = ZERO;
                    quantum_end_next_s = 1'b1;
                end else if (bus.Instr_Valid && (count_r != ZERO)) begin
                    count_next_s = count_r - ONE;
                end else begin
                    count_next_s = count_r;
                end
            end
            PREEMPT: begin
                if (bus.Context_Ack || bus.Halt) begin
                    state_next_s = IDLE;
                end else begin
                    state_next_s = PREEMPT;
                end
            end
            default: begin
                state_next_s = IDLE;
                count_next_s = ZERO;
            end
        endcase
    end

    // State, counter, quantum register and registered expiry pulse.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_r       <= IDLE;
            count_r       <= ZERO;
            quantum_r     <= DEFAULT_Q;
            quantum_end_r <= 1'b0;
        end else begin
            state_r       <= state_next_s;
            count_r       <= count_next_s;
            quantum_r     <= quantum_next_s;
            quantum_end_r <= quantum_end_next_s;
        end
    end

    assign bus.quantum_end = quantum_end_r;
    assign bus.Preempt     = (state_r == PREEMPT);
    assign bus.Running     = (state_r == RUN);
    assign bus.Remaining   = count_r;
endmodule

// File: tb/tb_quantum_timer.sv
// Directed bench for quantum_timer. Each step drives the inputs, pushes the
// expected post-edge outputs onto a scoreboard queue, then pops and compares
// them one time unit after the rising edge.
module tb_quantum_timer;
    localparam int WIDTH = 32;

    logic Clock;
    logic Reset;

    quantum_timer_if #(.WIDTH(WIDTH)) bus ();

    quantum_timer #(.WIDTH(WIDTH), .DEFAULT_QUANTUM(64)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus)
    );

    typedef struct {
        string            tag;
        logic             qe;
        logic             pre;
        logic             run;
        logic [WIDTH-1:0] rem;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // One clock step: drive inputs, queue the expectation, sample after edge.
    task automatic step(input string tag,
                        input logic rst, input logic sq, input logic [WIDTH-1:0] qin,
                        input logic st, input logic iv, input logic h, input logic ack,
                        input logic eqe, input logic epre, input logic erun,
                        input logic [WIDTH-1:0] erem);
        exp_t e;
        logic [WIDTH+2:0] obs;
        logic [WIDTH+2:0] want;
        Reset           = rst;
        bus.Set_Quantum = sq;
        bus.Quantum_In  = qin;
        bus.Start       = st;
        bus.Instr_Valid = iv;
        bus.Halt        = h;
        bus.Context_Ack = ack;
        e.tag = tag; e.qe = eqe; e.pre = epre; e.run = erun; e.rem = erem;
        sb.push_back(e);
        @(posedge Clock);
        #1;
        e    = sb.pop_front();
        obs  = {bus.quantum_end, bus.Preempt, bus.Running, bus.Remaining};
        want = {e.qe, e.pre, e.run, e.rem};
        checks++;
        assert (obs === want) else begin
            errors++;
            $error("FAIL %s: observed qe/pre/run/rem=%b%b%b/%0d expected %b%b%b/%0d",
                   e.tag, obs[WIDTH+2], obs[WIDTH+1], obs[WIDTH], obs[WIDTH-1:0],
                   e.qe, e.pre, e.run, e.rem);
        end
    endtask

    initial begin
        Reset = 1'b1;
        bus.Set_Quantum = 1'b0; bus.Quantum_In = '0; bus.Start = 1'b0;
        bus.Instr_Valid = 1'b0; bus.Halt = 1'b0; bus.Context_Ack = 1'b0;

        // Reset state; IDLE ignores valid/halt/ack.
        step("reset",      1'b1, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step("idle_ign",   1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        // 1: default quantum of 64, consecutive valids.
        step("t1_start",   1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd64);
        for (int i = 1; i <= 64; i++) begin
            step("t1_count", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                 (i == 64), (i == 64), (i < 64), 32'(64 - i));
        end
        for (int i = 0; i < 3; i++) begin
            step("t1_hold",  1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        end
        step("t1_ack",     1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        // 2: quantum 5, valids on alternate cycles; expiry 9 cycles in.
        step("t2_load",    1'b0, 1'b1, 32'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step("t2_start",   1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
        for (int i = 1; i <= 9; i++) begin
            step("t2_alt",   1'b0, 1'b0, 32'd0, 1'b0, (i % 2 == 1), 1'b0, 1'b0,
                 (i == 9), (i == 9), (i < 9), 32'(5 - (i + 1) / 2));
        end
        step("t2_ack",     1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        step("t2_zero",    1'b0, 1'b1, 32'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // 3: quantum still 5; Halt with Instr_Valid ends the run quietly.
        step("t3_start",   1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
        for (int i = 1; i <= 3; i++) begin
            step("t3_count", 1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'(5 - i));
        end
        step("t3_halt",    1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step("t3_after",   1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // 4: restart at remaining 1 reloads; same-cycle valid not counted.
        step("t4_start",   1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
        for (int i = 1; i <= 4; i++) begin
            step("t4_pre",   1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'(5 - i));
        end
        step("t4_restart", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
        for (int i = 1; i <= 5; i++) begin
            step("t4_post",  1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0,
                 (i == 5), (i == 5), (i < 5), 32'(5 - i));
        end
        step("t4_ack",     1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        // Set_Quantum with Start uses the new value; mid-run load waits.
        step("sq_start",   1'b0, 1'b1, 32'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd7);
        step("sq_midrun",  1'b0, 1'b1, 32'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd6);
        step("sq_restart", 1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
        step("sq_valid",   1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);

        // 5: reset with remaining 2 in RUN; quantum back to 64.
        step("t5_reset",   1'b1, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
        step("t5_start",   1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd64);
        step("t5_halt",    1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // 6: PREEMPT ignores Start/Instr_Valid until acknowledged.
        step("t6_start",   1'b0, 1'b1, 32'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
        step("t6_v1",      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
        step("t6_v2",      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) begin
            step("t6_ignore", 1'b0, 1'b0, 32'd0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 32'd0);
        end
        step("t6_ack",     1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        // Halt plus Context_Ack together leaves PREEMPT as well.
        step("hk_start",   1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
        step("hk_v1",      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
        step("hk_v2",      1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step("hk_both",    1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0);

        // Halt alone also leaves PREEMPT.
        step("h_start",    1'b0, 1'b0, 32'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
        step("h_v1",       1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'd1);
        step("h_v2",       1'b0, 1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'd0);
        step("h_halt",     1'b0, 1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
